// File: rtl/wb_csr_commit_if.sv
// ------------------------------------------------------------------
// wb_csr_commit_if : MEM->WB handshake and WB<->CSR-file bus bundle.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface wb_csr_commit_if;
  logic        ms_valid;
  logic        ws_allow_in;
  logic [31:0] ms_pc;
  logic [2:0]  ms_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj_value;
  logic [31:0] ms_rd_value;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic [31:0] ms_vaddr;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        has_int;
  logic [31:0] csr_rvalue;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic        flush;
  logic [31:0] flush_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output ms_valid, ms_pc, ms_op, ms_csr_num, ms_rj_value, ms_rd_value,
           ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_gr_we, ms_dest,
           ms_result, has_int, csr_rvalue, ex_entry, ertn_entry,
    input  ws_allow_in, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_vaddr, wb_pc, ertn_flush,
           flush, flush_pc, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  ms_valid, ms_pc, ms_op, ms_csr_num, ms_rj_value, ms_rd_value,
           ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_gr_we, ms_dest,
           ms_result, has_int, csr_rvalue, ex_entry, ertn_entry,
    output ws_allow_in, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_vaddr, wb_pc, ertn_flush,
           flush, flush_pc, rf_we, rf_waddr, rf_wdata
  );
endinterface

`default_nettype wire

// File: rtl/wb_csr_commit.sv
// ------------------------------------------------------------------
// wb_csr_commit : writeback commit unit - CSR access, exception/ertn
//                 resolution, pipeline flush and wrong-path bubbles.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_csr_commit #(
  parameter int FLUSH_BUBBLES = 1
) (
  input wire            clk,
  input wire            reset,
  wb_csr_commit_if.slave bus
);

  localparam logic [2:0] c_op_csrrd   = 3'd1;
  localparam logic [2:0] c_op_csrwr   = 3'd2;
  localparam logic [2:0] c_op_csrxchg = 3'd3;
  localparam logic [2:0] c_op_ertn    = 3'd4;
  localparam logic [2:0] c_op_syscall = 3'd5;
  localparam logic [2:0] c_op_break   = 3'd6;
  localparam logic [5:0] c_ecode_int  = 6'h00;
  localparam logic [5:0] c_ecode_sys  = 6'h0B;
  localparam logic [5:0] c_ecode_brk  = 6'h0C;
  localparam logic [2:0] c_bubble_load = 3'(FLUSH_BUBBLES);
  localparam bit         c_has_bubbles = (FLUSH_BUBBLES > 0);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [13:0] csr_num;
    logic [31:0] rj_value;
    logic [31:0] rd_value;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] vaddr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        intr;
  } ws_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ws_valid_q, ws_valid_d;
  ws_t         ws_q, ws_d;

  logic        w_allow_in;
  logic        w_accept;
  logic        w_exception;
  logic        w_is_csr_op;
  logic        w_csr_access;
  logic        w_csr_we;
  logic        w_ertn;
  logic        w_flush;
  logic [5:0]  w_ecode;
  logic [8:0]  w_esubcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ws_valid_q <= ws_valid_d;
      ws_q       <= ws_d;
    end
  end

  // Bubble window: only the flush cycle blocks acceptance while in RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_allow_in = 1'b0;
    case (state_q)
      ST_RUN: begin
        w_allow_in = 1'b1;
        if (w_flush && c_has_bubbles) begin
          state_d = ST_BUBBLE;
          cnt_d   = c_bubble_load;
        end
      end
      ST_BUBBLE: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_accept = bus.ms_valid & w_allow_in & ~w_flush;

  always_comb begin
    ws_valid_d = w_accept;
    ws_d       = ws_q;
    if (w_accept) begin
      ws_d.pc       = bus.ms_pc;
      ws_d.op       = bus.ms_op;
      ws_d.csr_num  = bus.ms_csr_num;
      ws_d.rj_value = bus.ms_rj_value;
      ws_d.rd_value = bus.ms_rd_value;
      ws_d.ex       = bus.ms_ex;
      ws_d.ecode    = bus.ms_ecode;
      ws_d.esubcode = bus.ms_esubcode;
      ws_d.vaddr    = bus.ms_vaddr;
      ws_d.gr_we    = bus.ms_gr_we;
      ws_d.dest     = bus.ms_dest;
      ws_d.result   = bus.ms_result;
      ws_d.intr     = bus.has_int;
    end
  end

  assign w_exception = ws_valid_q & (ws_q.intr | ws_q.ex |
                                     (ws_q.op == c_op_syscall) |
                                     (ws_q.op == c_op_break));

  // Interrupt outranks upstream faults, which outrank syscall/break.
  always_comb begin
    w_ecode    = '0;
    w_esubcode = '0;
    if (w_exception) begin
      if (ws_q.intr) begin
        w_ecode = c_ecode_int;
      end else if (ws_q.ex) begin
        w_ecode    = ws_q.ecode;
        w_esubcode = ws_q.esubcode;
      end else if (ws_q.op == c_op_syscall) begin
        w_ecode = c_ecode_sys;
      end else begin
        w_ecode = c_ecode_brk;
      end
    end
  end

  assign w_is_csr_op  = (ws_q.op == c_op_csrrd) | (ws_q.op == c_op_csrwr) |
                        (ws_q.op == c_op_csrxchg);
  assign w_csr_access = ws_valid_q & w_is_csr_op & ~w_exception;
  assign w_csr_we     = w_csr_access & (ws_q.op != c_op_csrrd);
  assign w_ertn       = ws_valid_q & (ws_q.op == c_op_ertn) & ~w_exception;
  assign w_flush      = w_exception | w_ertn;

  assign bus.ws_allow_in = w_allow_in;
  assign bus.csr_re      = w_csr_access;
  assign bus.csr_num     = w_csr_access ? ws_q.csr_num : 14'd0;
  assign bus.csr_we      = w_csr_we;
  assign bus.csr_wmask   = !w_csr_we ? 32'd0 :
                           (ws_q.op == c_op_csrwr) ? 32'hFFFF_FFFF : ws_q.rj_value;
  assign bus.csr_wvalue  = w_csr_we ? ws_q.rd_value : 32'd0;

  assign bus.wb_ex       = w_exception;
  assign bus.wb_ecode    = w_ecode;
  assign bus.wb_esubcode = w_esubcode;
  assign bus.wb_vaddr    = ws_valid_q ? ws_q.vaddr : 32'd0;
  assign bus.wb_pc       = ws_valid_q ? ws_q.pc : 32'd0;
  assign bus.ertn_flush  = w_ertn;
  assign bus.flush       = w_flush;
  assign bus.flush_pc    = w_exception ? bus.ex_entry :
                           w_ertn      ? bus.ertn_entry : 32'd0;

  // CSR ops return the old CSR value, read in the same cycle as the write.
  assign bus.rf_we    = ws_valid_q & ws_q.gr_we & ~w_exception & (ws_q.op != c_op_ertn);
  assign bus.rf_waddr = ws_valid_q ? ws_q.dest : 5'd0;
  assign bus.rf_wdata = !ws_valid_q ? 32'd0 :
                        w_is_csr_op ? bus.csr_rvalue : ws_q.result;

endmodule

`default_nettype wire

// File: tb/tb_wb_csr_commit.sv
// ------------------------------------------------------------------
// tb_wb_csr_commit : vector table, corner sequences and random run
//                    against a behavioural model of wb_csr_commit.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_wb_csr_commit;

  localparam int          B          = 1;
  localparam logic [31:0] EX_ENTRY   = 32'h1C00_8000;
  localparam logic [31:0] ERTN_ENTRY = 32'h1C00_0200;

  typedef struct {
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rd;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        intr;
    logic [31:0] pc;
    logic [31:0] rval;
  } stim_t;

  typedef struct {
    logic        csr_re;
    logic        csr_we;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        wb_ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn;
    logic        flush;
    logic [31:0] fpc;
    logic        rf_we;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_csr_commit_if bus();

  wb_csr_commit #(.FLUSH_BUBBLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input stim_t s);
    bus.ms_valid    = v;
    bus.ms_pc       = s.pc;
    bus.ms_op       = s.op;
    bus.ms_csr_num  = s.num;
    bus.ms_rj_value = s.rj;
    bus.ms_rd_value = s.rd;
    bus.ms_ex       = s.ex;
    bus.ms_ecode    = s.ecode;
    bus.ms_esubcode = s.esub;
    bus.ms_vaddr    = s.vaddr;
    bus.ms_gr_we    = s.gr_we;
    bus.ms_dest     = s.dest;
    bus.ms_result   = s.result;
    bus.has_int     = s.intr;
  endtask

  // Reference: what a committing instruction c must produce this cycle.
  function automatic exp_t model(input bit v, input stim_t c, input logic [31:0] rval,
                                 input logic [31:0] xe, input logic [31:0] re);
    exp_t e = '{default: '0};
    bit   exc;
    bit   is_csr;
    if (v) begin
      exc    = c.intr || c.ex || c.op == 3'd5 || c.op == 3'd6;
      is_csr = c.op inside {3'd1, 3'd2, 3'd3};
      e.wb_ex = exc;
      if (exc) begin
        if (c.intr)            e.ecode = 6'h00;
        else if (c.ex)         begin e.ecode = c.ecode; e.esub = c.esub; end
        else if (c.op == 3'd5) e.ecode = 6'h0B;
        else                   e.ecode = 6'h0C;
      end
      e.ertn   = (c.op == 3'd4) && !exc;
      e.csr_re = is_csr && !exc;
      e.csr_we = e.csr_re && c.op != 3'd1;
      if (e.csr_we) begin
        e.wmask  = (c.op == 3'd2) ? 32'hFFFF_FFFF : c.rj;
        e.wvalue = c.rd;
      end
      e.rf_we = c.gr_we && !exc && c.op != 3'd4;
      e.wdata = is_csr ? rval : c.result;
    end
    e.flush = e.wb_ex || e.ertn;
    e.fpc   = e.wb_ex ? xe : (e.ertn ? re : 32'd0);
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e, input bit allow,
                           input bit v, input stim_t c);
    chk({tag, ".allow_in"},   bus.ws_allow_in, allow);
    chk({tag, ".csr_re"},     bus.csr_re,      e.csr_re);
    chk({tag, ".csr_num"},    bus.csr_num,     e.csr_re ? c.num : 14'd0);
    chk({tag, ".csr_we"},     bus.csr_we,      e.csr_we);
    if (!(e.csr_re && !e.csr_we)) begin
      chk({tag, ".csr_wmask"},  bus.csr_wmask,  e.wmask);
      chk({tag, ".csr_wvalue"}, bus.csr_wvalue, e.wvalue);
    end
    chk({tag, ".wb_ex"},      bus.wb_ex,       e.wb_ex);
    if (e.wb_ex) begin
      chk({tag, ".wb_ecode"},    bus.wb_ecode,    e.ecode);
      chk({tag, ".wb_esubcode"}, bus.wb_esubcode, e.esub);
    end
    if (v) begin
      chk({tag, ".wb_pc"},    bus.wb_pc,    c.pc);
      chk({tag, ".wb_vaddr"}, bus.wb_vaddr, c.vaddr);
    end
    chk({tag, ".ertn_flush"}, bus.ertn_flush,  e.ertn);
    chk({tag, ".flush"},      bus.flush,       e.flush);
    chk({tag, ".flush_pc"},   bus.flush_pc,    e.fpc);
    chk({tag, ".rf_we"},      bus.rf_we,       e.rf_we);
    if (e.rf_we) begin
      chk({tag, ".rf_waddr"}, bus.rf_waddr, c.dest);
      chk({tag, ".rf_wdata"}, bus.rf_wdata, e.wdata);
    end
  endtask

  vec_t  vec[11];
  stim_t zero_s;
  stim_t sys_s;
  stim_t x_s;
  exp_t  e;

  // Model state for the random phase.
  bit    m_valid;
  stim_t m_cur;
  int    m_stall;

  initial begin
    zero_s = '{default: '0};

    //            op    num      rj            rd            ex    ecode  esub   vaddr        gr_we dest   result        intr  pc            rval
    vec[0].s  = '{3'd2, 14'h30, 32'h0,        32'h12345678, 1'b0, 6'h00, 9'h00, 32'h0,       1'b1, 5'd4,  32'hCAFE0001, 1'b0, 32'h1C000010, 32'hAAAA0000};
    vec[0].e  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0, 6'h00, 9'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0000};
    vec[1].s  = '{3'd3, 14'h30, 32'h0000FF00, 32'h1234ABCD, 1'b0, 6'h00, 9'h00, 32'h0,       1'b1, 5'd7,  32'hCAFE0002, 1'b0, 32'h1C000014, 32'h55551111};
    vec[1].e  = '{1'b1, 1'b1, 32'h0000FF00, 32'h1234ABCD, 1'b0, 6'h00, 9'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55551111};
    vec[2].s  = '{3'd1, 14'h30, 32'h0000FF00, 32'h1234ABCD, 1'b0, 6'h00, 9'h00, 32'h0,       1'b1, 5'd7,  32'hCAFE0003, 1'b0, 32'h1C000018, 32'h55551111};
    vec[2].e  = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 6'h00, 9'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55551111};
    vec[3].s  = '{3'd2, 14'h30, 32'h0,        32'h12345678, 1'b0, 6'h00, 9'h00, 32'h0,       1'b1, 5'd4,  32'hCAFE0004, 1'b1, 32'h1C000020, 32'hAAAA0000};
    vec[3].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 6'h00, 9'h0, 1'b0, 1'b1, EX_ENTRY, 1'b0, 32'h0};
    vec[4].s  = '{3'd0, 14'h00, 32'h0,        32'h0,        1'b1, 6'h08, 9'h00, 32'h1,       1'b1, 5'd3,  32'h00000077, 1'b0, 32'h1C000024, 32'h0};
    vec[4].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 6'h08, 9'h0, 1'b0, 1'b1, EX_ENTRY, 1'b0, 32'h0};
    vec[5].s  = '{3'd4, 14'h00, 32'h0,        32'h0,        1'b0, 6'h00, 9'h00, 32'h0,       1'b1, 5'd2,  32'h00000099, 1'b0, 32'h1C000028, 32'h0};
    vec[5].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 6'h00, 9'h0, 1'b1, 1'b1, ERTN_ENTRY, 1'b0, 32'h0};
    vec[6].s  = '{3'd6, 14'h00, 32'h0,        32'h0,        1'b0, 6'h00, 9'h00, 32'h0,       1'b0, 5'd0,  32'h0,        1'b0, 32'h1C00002C, 32'h0};
    vec[6].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 6'h0C, 9'h0, 1'b0, 1'b1, EX_ENTRY, 1'b0, 32'h0};
    vec[7].s  = '{3'd4, 14'h00, 32'h0,        32'h0,        1'b0, 6'h00, 9'h00, 32'h0,       1'b0, 5'd0,  32'h0,        1'b1, 32'h1C000030, 32'h0};
    vec[7].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 6'h00, 9'h0, 1'b0, 1'b1, EX_ENTRY, 1'b0, 32'h0};
    vec[8].s  = '{3'd5, 14'h00, 32'h0,        32'h0,        1'b1, 6'h08, 9'h01, 32'h40,      1'b0, 5'd0,  32'h0,        1'b0, 32'h1C000034, 32'h0};
    vec[8].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 6'h08, 9'h1, 1'b0, 1'b1, EX_ENTRY, 1'b0, 32'h0};
    vec[9].s  = '{3'd0, 14'h00, 32'h0,        32'h0,        1'b0, 6'h00, 9'h00, 32'h0,       1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 32'h1C000038, 32'h0};
    vec[9].e  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 6'h00, 9'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
    vec[10].s = '{3'd3, 14'h05, 32'hF0F0F0F0, 32'h1,        1'b1, 6'h03, 9'h00, 32'h80,      1'b1, 5'd9,  32'h0,        1'b0, 32'h1C00003C, 32'h0};
    vec[10].e = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 6'h03, 9'h0, 1'b0, 1'b1, EX_ENTRY, 1'b0, 32'h0};

    // Reset state.
    reset          = 1'b1;
    drive(1'b0, zero_s);
    bus.csr_rvalue = 32'h0;
    bus.ex_entry   = EX_ENTRY;
    bus.ertn_entry = ERTN_ENTRY;
    @(negedge clk);
    step();
    check_all("reset", '{default: '0}, 1'b1, 1'b0, zero_s);
    chk("reset.wb_pc",       bus.wb_pc,       32'd0);
    chk("reset.wb_vaddr",    bus.wb_vaddr,    32'd0);
    chk("reset.wb_ecode",    bus.wb_ecode,    32'd0);
    chk("reset.wb_esubcode", bus.wb_esubcode, 32'd0);
    chk("reset.rf_waddr",    bus.rf_waddr,    32'd0);
    chk("reset.rf_wdata",    bus.rf_wdata,    32'd0);
    reset = 1'b0;
    step();

    // Table: issue each instruction alone, check its commit cycle and the cycle after.
    foreach (vec[i]) begin
      drive(1'b1, vec[i].s);
      step();
      drive(1'b0, vec[i].s);
      bus.csr_rvalue = vec[i].s.rval;
      #1;
      check_all($sformatf("vec%0d", i), vec[i].e, 1'b1, 1'b1, vec[i].s);
      step();
      chk($sformatf("vec%0d.next_rf_we", i), bus.rf_we, 1'b0);
      chk($sformatf("vec%0d.next_flush", i), bus.flush, 1'b0);
      chk($sformatf("vec%0d.next_allow", i), bus.ws_allow_in, !(vec[i].e.flush && B > 0));
      repeat (B + 1) step();
    end

    // Syscall flush with ms_valid held high: no accept in the flush or bubble cycle.
    sys_s = zero_s; sys_s.op = 3'd5; sys_s.pc = 32'h1C000100;
    x_s   = zero_s; x_s.gr_we = 1'b1; x_s.dest = 5'd5; x_s.result = 32'h55; x_s.pc = 32'h1C000104;
    drive(1'b1, sys_s);
    step();
    drive(1'b1, x_s);
    #1;
    chk("sys.wb_ex",    bus.wb_ex,       1'b1);
    chk("sys.ecode",    bus.wb_ecode,    6'h0B);
    chk("sys.wb_pc",    bus.wb_pc,       32'h1C000100);
    chk("sys.flush",    bus.flush,       1'b1);
    chk("sys.flush_pc", bus.flush_pc,    32'h1C008000);
    chk("sys.allow0",   bus.ws_allow_in, 1'b1);
    step();
    chk("sys.allow1",   bus.ws_allow_in, 1'b0);
    chk("sys.rf_we1",   bus.rf_we,       1'b0);
    chk("sys.flush1",   bus.flush,       1'b0);
    step();
    chk("sys.allow2",   bus.ws_allow_in, 1'b1);
    chk("sys.rf_we2",   bus.rf_we,       1'b0);
    step();
    chk("sys.rf_we3",   bus.rf_we,       1'b1);
    chk("sys.rf_wdata3", bus.rf_wdata,   32'h55);
    chk("sys.rf_waddr3", bus.rf_waddr,   5'd5);
    drive(1'b0, zero_s);
    step();

    // Reset in the bubble window, then four back-to-back plain instructions.
    drive(1'b1, sys_s);
    step();
    drive(1'b0, zero_s);
    step();
    chk("rstbub.in_bubble", bus.ws_allow_in, (B > 0) ? 1'b0 : 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("rstbub", '{default: '0}, 1'b1, 1'b0, zero_s);
    for (int k = 0; k < 4; k++) begin
      x_s = zero_s; x_s.gr_we = 1'b1; x_s.dest = 5'(k + 1);
      x_s.result = 32'h100 + 32'(k); x_s.pc = 32'h1C000200 + 32'(4 * k);
      drive(1'b1, x_s);
      step();
      chk($sformatf("stream%0d.allow", k),    bus.ws_allow_in, 1'b1);
      chk($sformatf("stream%0d.rf_we", k),    bus.rf_we,       1'b1);
      chk($sformatf("stream%0d.rf_wdata", k), bus.rf_wdata,    32'h100 + 32'(k));
      chk($sformatf("stream%0d.rf_waddr", k), bus.rf_waddr,    32'(k + 1));
    end
    drive(1'b0, zero_s);
    step();
    chk("stream.end_rf_we", bus.rf_we, 1'b0);

    // Random traffic against the model.
    m_valid = 1'b0;
    m_cur   = zero_s;
    m_stall = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      stim_t s;
      bit    v;
      s.op     = 3'($urandom_range(0, 6));
      s.num    = 14'($urandom);
      s.rj     = $urandom;
      s.rd     = $urandom;
      s.ex     = ($urandom_range(0, 9) == 0);
      s.ecode  = 6'($urandom);
      s.esub   = 9'($urandom);
      s.vaddr  = $urandom;
      s.gr_we  = 1'($urandom);
      s.dest   = 5'($urandom);
      s.result = $urandom;
      s.intr   = ($urandom_range(0, 7) == 0);
      s.pc     = $urandom;
      s.rval   = 32'h0;
      v        = ($urandom_range(0, 9) < 7);
      reset    = ($urandom_range(0, 59) == 0);
      drive(v, s);
      bus.csr_rvalue = $urandom;
      bus.ex_entry   = $urandom;
      bus.ertn_entry = $urandom;
      #1;
      e = model(m_valid, m_cur, bus.csr_rvalue, bus.ex_entry, bus.ertn_entry);
      check_all("rnd", e, m_stall == 0, m_valid, m_cur);
      if (reset) begin
        m_valid = 1'b0;
        m_stall = 0;
      end else begin
        m_valid = v && m_stall == 0 && !e.flush;
        if (m_valid) m_cur = s;
        if (e.flush && B > 0) m_stall = B;
        else if (m_stall > 0) m_stall--;
      end
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
